// File: rtl/cfg_readback_serializer.sv
// Configuration readback: shifts register bytes out on MISO, MSB first.
// Define CFG_READBACK_PARITY_EN to append an even-parity bit per byte.
module cfg_readback_serializer #(
  parameter int NUM_REGS = 36,
  parameter int ADDR_W   = 6,
  parameter int CFG_W    = 512
) (
  input  logic              SCK,
  input  logic              RST,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic              cs_active,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              byte_done,
  output logic [ADDR_W-1:0] cur_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef CFG_READBACK_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef CFG_READBACK_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [ADDR_W-1:0] fetch_addr;
  logic [7:0]        fetch_byte;
  logic              abort;
  logic              advance;

  assign fetch_addr = (state_q == IDLE) ? start_addr
                    : ADDR_W'(addr_q + 1'b1);

  // Unimplemented addresses read as zero.
  always_comb begin
    fetch_byte = '0;
    if (int'(fetch_addr) < NUM_REGS)
      fetch_byte = cfg_data[{fetch_addr, 3'b000} +: 8];
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
`ifdef CFG_READBACK_PARITY_EN
    par_d   = par_q;
`endif
    abort   = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_start && cs_active) begin
          state_d = SHIFT;
          sh_d    = fetch_byte;
          cnt_d   = '0;
          addr_d  = start_addr;
          rem_d   = (burst_len == '0) ? ADDR_W'(1)
                                      : burst_len;
`ifdef CFG_READBACK_PARITY_EN
          par_d   = ^fetch_byte;
`endif
        end
      end
      SHIFT: begin
        unique case (1'b1)
          !cs_active:
            abort = 1'b1;
          cs_active && (cnt_q == 3'd7): begin
`ifdef CFG_READBACK_PARITY_EN
            state_d = PAR;
`else
            advance = 1'b1;
`endif
          end
          default: begin
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = 3'(cnt_q + 3'd1);
          end
        endcase
      end
`ifdef CFG_READBACK_PARITY_EN
      PAR: begin
        if (!cs_active) abort = 1'b1;
        else            advance = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      sh_d    = '0;
      cnt_d   = '0;
      rem_d   = '0;
    end else if (advance) begin
      // Back-to-back bytes: next bit7 follows bit0 directly.
      if (rem_q > ADDR_W'(1)) begin
        state_d = SHIFT;
        rem_d   = ADDR_W'(rem_q - 1'b1);
        addr_d  = fetch_addr;
        sh_d    = fetch_byte;
        cnt_d   = '0;
`ifdef CFG_READBACK_PARITY_EN
        par_d   = ^fetch_byte;
`endif
      end else begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
        rem_d   = '0;
      end
    end
  end

  always_ff @(posedge SCK) begin
    if (RST) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
`ifdef CFG_READBACK_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
`ifdef CFG_READBACK_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    miso      = 1'b0;
    byte_done = 1'b0;
    unique case (state_q)
      SHIFT: begin
        miso = sh_q[7];
`ifndef CFG_READBACK_PARITY_EN
        byte_done = (cnt_q == 3'd7);
`endif
      end
`ifdef CFG_READBACK_PARITY_EN
      PAR: begin
        miso      = par_q;
        byte_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign miso_oe  = busy;
  assign cur_addr = addr_q;

endmodule

// File: tb/tb_cfg_readback_serializer.sv
// Bench for cfg_readback_serializer: per-cycle expected
// output records queued at stimulus time, popped each cycle.
module tb_cfg_readback_serializer;

  localparam int AW = 6;
  localparam int CW = 512;

  logic          SCK = 1'b0;
  logic          RST;
  logic [CW-1:0] cfg_data;
  logic          rd_start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] burst_len;
  logic          cs_active;
  logic          miso;
  logic          miso_oe;
  logic          busy;
  logic          byte_done;
  logic [AW-1:0] cur_addr;

  cfg_readback_serializer #(
    .NUM_REGS(36),
    .ADDR_W  (AW),
    .CFG_W   (CW)
  ) dut (
    .SCK       (SCK),
    .RST       (RST),
    .cfg_data  (cfg_data),
    .rd_start  (rd_start),
    .start_addr(start_addr),
    .burst_len (burst_len),
    .cs_active (cs_active),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .busy      (busy),
    .byte_done (byte_done),
    .cur_addr  (cur_addr)
  );

  always #5 SCK = ~SCK;

  typedef struct {
    logic          m;
    logic          oe;
    logic          bsy;
    logic          dn;
    logic [AW-1:0] a;
    bit            chk;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    int            n;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
  } vec_t;

  exp_t  expq[$];
  vec_t  vecs[6];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string tag    = "reset";

  task automatic push_rec(input logic m, input logic oe,
                          input logic bsy, input logic dn,
                          input logic [AW-1:0] a,
                          input bit chk);
    exp_t e;
    e.m = m; e.oe = oe; e.bsy = bsy;
    e.dn = dn; e.a = a; e.chk = chk;
    expq.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] b,
                           input logic [AW-1:0] a);
    bit par_en;
`ifdef CFG_READBACK_PARITY_EN
    par_en = 1'b1;
`else
    par_en = 1'b0;
`endif
    for (int i = 7; i >= 0; i--)
      push_rec(b[i], 1'b1, 1'b1,
               (i == 0) && !par_en, a, 1'b1);
    if (par_en)
      push_rec(^b, 1'b1, 1'b1, 1'b1, a, 1'b1);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++)
      push_rec(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge SCK);
    #1;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (miso !== e.m || miso_oe !== e.oe ||
          busy !== e.bsy || byte_done !== e.dn ||
          (e.chk && cur_addr !== e.a)) begin
        errors++;
        $display("FAIL %s cyc%0d: got m=%b oe=%b bsy=%b dn=%b a=%0d want m=%b oe=%b bsy=%b dn=%b a=%0d",
                 tag, cyc, miso, miso_oe, busy,
                 byte_done, cur_addr, e.m, e.oe,
                 e.bsy, e.dn, e.a);
      end
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (expq.size() > 0 && budget < 400) begin
      step();
      budget++;
    end
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: %0d left want 0",
               tag, expq.size());
      expq.delete();
    end
  endtask

  task automatic set_reg(input int k, input logic [7:0] v);
    cfg_data[k*8 +: 8] = v;
  endtask

  initial begin
    RST        = 1'b1;
    rd_start   = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    cs_active  = 1'b1;
    cfg_data   = '0;
    set_reg(0,  8'h81);
    set_reg(1,  8'hC0);
    set_reg(2,  8'h07);
    set_reg(5,  8'hA5);
    set_reg(6,  8'h3E);
    set_reg(10, 8'hFF);
    set_reg(11, 8'h5A);
    set_reg(34, 8'h3C);
    set_reg(35, 8'hC3);
    set_reg(36, 8'hEE);
    set_reg(40, 8'h99);
    set_reg(63, 8'h77);

    vecs[0] = '{6'd5,  6'd1, 1, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{6'd34, 6'd3, 3, 8'h3C, 8'hC3, 8'h00};
    vecs[2] = '{6'd63, 6'd2, 2, 8'h00, 8'h81, 8'h00};
    vecs[3] = '{6'd2,  6'd0, 1, 8'h07, 8'h00, 8'h00};
    vecs[4] = '{6'd10, 6'd2, 2, 8'hFF, 8'h5A, 8'h00};
    vecs[5] = '{6'd40, 6'd1, 1, 8'h00, 8'h00, 8'h00};

    push_rec(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    step();
    RST = 1'b0;
    push_idle(1);
    drain();

    foreach (vecs[v]) begin
      tag = $sformatf("vec%0d", v);
      start_addr = vecs[v].addr;
      burst_len  = vecs[v].len;
      rd_start   = 1'b1;
      push_byte(vecs[v].b0, vecs[v].addr);
      if (vecs[v].n > 1)
        push_byte(vecs[v].b1, AW'(vecs[v].addr + 1));
      if (vecs[v].n > 2)
        push_byte(vecs[v].b2, AW'(vecs[v].addr + 2));
      push_idle(1);
      step();
      rd_start = 1'b0;
      drain();
    end

    tag = "cs_low_start";
    cs_active  = 1'b0;
    start_addr = 6'd5;
    burst_len  = 6'd1;
    rd_start   = 1'b1;
    push_idle(2);
    step();
    rd_start  = 1'b0;
    cs_active = 1'b1;
    drain();

    tag = "ignore_busy";
    start_addr = 6'd5;
    burst_len  = 6'd2;
    rd_start   = 1'b1;
    push_byte(8'hA5, 6'd5);
    push_byte(8'h3E, 6'd6);
    push_idle(1);
    step();
    rd_start = 1'b0;
    step();
    step();
    start_addr = 6'd20;
    burst_len  = 6'd5;
    rd_start   = 1'b1;
    step();
    rd_start = 1'b0;
    drain();

    tag = "abort";
    start_addr = 6'd10;
    burst_len  = 6'd1;
    rd_start   = 1'b1;
    for (int i = 0; i < 3; i++)
      push_rec(1'b1, 1'b1, 1'b1, 1'b0, 6'd10, 1'b1);
    push_idle(3);
    push_byte(8'hA5, 6'd5);
    push_idle(1);
    step();
    rd_start = 1'b0;
    step();
    step();
    cs_active = 1'b0;
    step();
    cs_active = 1'b1;
    step();
    step();
    start_addr = 6'd5;
    burst_len  = 6'd1;
    rd_start   = 1'b1;
    step();
    rd_start = 1'b0;
    drain();

    tag = "reset_mid";
    start_addr = 6'd0;
    burst_len  = 6'd4;
    rd_start   = 1'b1;
    push_byte(8'h81, 6'd0);
    push_rec(1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 1'b1);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    step();
    rd_start = 1'b0;
    while (expq.size() > 1) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    push_idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
